// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serializer.
// Holds the FSM state encoding, the idle line level and a width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        DONE
    } state_t;

    localparam logic LINE_IDLE = 1'b0;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Bit-period divider: strobes bit_end on the last of every DIV cycles.
// Cleared on word acceptance; idles at zero while disabled.
module piso_bit_timer
    import piso_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int CW = clog2(DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !en || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DIV       = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [WIDTH-1:0] in_l,
    input  logic             in_valid,
    output logic             o_ready,
    output logic             o_sd,
    output logic             o_frame,
    output logic             o_done
);

    localparam int BW = clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [BW-1:0]    bit_cnt;
    logic             accept;
    logic             timer_en;
    logic             bit_end;
`ifdef PISO_TX_PARITY_EN
    logic             par;
`endif

    function automatic logic head(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign accept = o_ready && in_valid;

`ifdef PISO_TX_PARITY_EN
    assign timer_en = (state == SHIFT) || (state == PARITY);
`else
    assign timer_en = (state == SHIFT);
`endif

    always_comb begin
        if (MSB_FIRST != 0) begin
            sreg_nxt = {sreg[WIDTH-2:0], LINE_IDLE};
        end else begin
            sreg_nxt = {LINE_IDLE, sreg[WIDTH-1:1]};
        end
    end

    piso_bit_timer #(
        .DIV(DIV)
    ) u_timer (
        .clk    (in_clk),
        .rst    (in_rst),
        .clr    (accept),
        .en     (timer_en),
        .bit_end(bit_end)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            o_ready <= 1'b1;
            o_sd    <= LINE_IDLE;
            o_frame <= 1'b0;
            o_done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        sreg    <= in_l;
                        bit_cnt <= '0;
                        o_ready <= 1'b0;
                        o_sd    <= head(in_l);
                        o_frame <= 1'b1;
`ifdef PISO_TX_PARITY_EN
                        par     <= ^in_l;
`endif
                    end else begin
                        state   <= IDLE;
                        o_ready <= 1'b1;
                        o_sd    <= LINE_IDLE;
                        o_frame <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
                            state   <= PARITY;
                            o_sd    <= par;
`else
                            state   <= DONE;
                            o_done  <= 1'b1;
                            o_frame <= 1'b0;
                            o_sd    <= LINE_IDLE;
                            o_ready <= 1'b1;
`endif
                        end else begin
                            sreg    <= sreg_nxt;
                            bit_cnt <= bit_cnt + BW'(1);
                            o_sd    <= head(sreg_nxt);
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state   <= DONE;
                        o_done  <= 1'b1;
                        o_frame <= 1'b0;
                        o_sd    <= LINE_IDLE;
                        o_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_sd    <= LINE_IDLE;
                    o_frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB/DIV=1 and LSB/DIV=3 instances,
// serial bits predicted into a queue and popped as frames appear.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] l0, l1;
    logic       v0, v1;
    logic       rdy0, sd0, fr0, dn0;
    logic       rdy1, sd1, fr1, dn1;
    logic       rdy, sd, fr, dn;
    int         sel = 0;
    int         total = 0;
    int         bad = 0;
    logic       q[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(4), .DIV(1), .MSB_FIRST(1)) u0 (
        .in_clk(clk), .in_rst(rst), .in_l(l0), .in_valid(v0),
        .o_ready(rdy0), .o_sd(sd0), .o_frame(fr0), .o_done(dn0)
    );

    piso_tx #(.WIDTH(4), .DIV(3), .MSB_FIRST(0)) u1 (
        .in_clk(clk), .in_rst(rst), .in_l(l1), .in_valid(v1),
        .o_ready(rdy1), .o_sd(sd1), .o_frame(fr1), .o_done(dn1)
    );

    assign rdy = (sel != 0) ? rdy1 : rdy0;
    assign sd  = (sel != 0) ? sd1  : sd0;
    assign fr  = (sel != 0) ? fr1  : fr0;
    assign dn  = (sel != 0) ? dn1  : dn0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    function automatic int word_cycles(input int s);
        int div;
        int nb;
        div = (s != 0) ? 3 : 1;
        nb = 4;
`ifdef PISO_TX_PARITY_EN
        nb = 5;
`endif
        return nb * div;
    endfunction

    task automatic push_word(input int s, input logic [3:0] w);
        int   div;
        logic b;
        div = (s != 0) ? 3 : 1;
        for (int n = 0; n < 4; n++) begin
            b = (s == 0) ? w[3-n] : w[n];
            repeat (div) q.push_back(b);
        end
`ifdef PISO_TX_PARITY_EN
        repeat (div) q.push_back(^w);
`endif
    endtask

    task automatic set_valid(input int s, input logic v);
        if (s != 0) v1 = v;
        else v0 = v;
    endtask

    task automatic set_l(input int s, input logic [3:0] w);
        if (s != 0) l1 = w;
        else l0 = w;
    endtask

    task automatic check_frame(input int n, input int poke);
        logic e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = (q.size() > 0) ? q.pop_front() : 1'bx;
            chk("frame", fr, 1'b1);
            chk("busy", rdy, 1'b0);
            chk("sd", sd, e);
            if (poke != 0 && c == 1) begin
                set_valid(sel, 1'b1);
                set_l(sel, 4'b1111);
            end
            if (poke != 0 && c == 2) set_valid(sel, 1'b0);
        end
        @(negedge clk);
        chk("done", dn, 1'b1);
        chk("done_frame", fr, 1'b0);
        chk("done_sd", sd, 1'b0);
        chk("done_ready", rdy, 1'b1);
    endtask

    task automatic send(input int s, input logic [3:0] w, input int poke);
        sel = s;
        @(negedge clk);
        set_l(s, w);
        set_valid(s, 1'b1);
        push_word(s, w);
        @(posedge clk);
        #1 set_valid(s, 1'b0);
        check_frame(word_cycles(s), poke);
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_ready", rdy, 1'b1);
        chk("idle_done", dn, 1'b0);
        chk("idle_frame", fr, 1'b0);
        chk("idle_sd", sd, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        l0 = '0;
        l1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_ready", rdy, 1'b1);
            chk("rst_sd", sd, 1'b0);
            chk("rst_frame", fr, 1'b0);
            chk("rst_done", dn, 1'b0);
        end
        rst = 1'b0;

        send(0, 4'b1011, 0);
        idle_check();

        send(1, 4'b0001, 0);
        idle_check();

        sel = 0;
        @(negedge clk);
        l0 = 4'b1100;
        v0 = 1'b1;
        push_word(0, 4'b1100);
        @(posedge clk);
        #1 l0 = 4'b0011;
        push_word(0, 4'b0011);
        check_frame(word_cycles(0), 0);
        @(posedge clk);
        #1 v0 = 1'b0;
        check_frame(word_cycles(0), 0);
        idle_check();

        send(0, 4'b0110, 1);
        idle_check();
        idle_check();

        sel = 0;
        @(negedge clk);
        l0 = 4'b1111;
        v0 = 1'b1;
        push_word(0, 4'b1111);
        @(posedge clk);
        #1 v0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_frame", fr, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", rdy, 1'b1);
        chk("arst_sd", sd, 1'b0);
        chk("arst_frame", fr, 1'b0);
        chk("arst_done", dn, 1'b0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle_check();
        idle_check();
        send(0, 4'b0011, 0);
        idle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
